uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the lab UART, the receive-side counterpart of the existing transmitter. It deserialises frames of 1 start bit, 8 data bits (LSB first), 1 parity bit and 1 or 2 stop bits from `rx_in`, checks parity and framing, and queues each received byte with its error flags in a small first-word-fall-through FIFO. The host side pops entries with `rd_en`. Baud divisor and frame format use the same conventions as the transmitter.

## Interface
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of 2, and at least 2.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-high; the clock is `clk`.
- `rx_en`  in  1  receiver enable.
- `baud_divisor`  in  14  bit period is `baud_divisor+1` clk cycles; a value below 3 is treated as 3.
- `two_stop`  in  1  1 = two stop bits are checked; 0 = one stop bit is checked.
- `odd_parity`  in  1  1 = odd parity; 0 = even parity.
- `rx_in`  in  1  serial line, idle high.
- `rd_en`  in  1  pops the FIFO head when `rx_valid` is 1.
- `err_clr`  in  1  clears `overrun_err`.
- `rx_data`  out  8  FIFO head data byte.
- `rx_valid`  out  1  FIFO not empty.
- `rx_parity_err`  out  1  parity error flag of the head entry.
- `rx_frame_err`  out  1  stop-bit error flag of the head entry.
- `overrun_err`  out  1  sticky; set when a frame is dropped because the FIFO is full.
- `fifo_full`  out  1  FIFO holds `FIFO_DEPTH` entries.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied entries.
- `rx_busy`  out  1  FSM is not in IDLE.

## Operation
- FSM states:
  - IDLE → START when `rx_en` is 1 and a falling edge is seen on the sampled line (previous sample 1, current sample 0).
  - START → DATA when the mid-bit sample is 0. If the mid-bit sample is 1 (false start), return to IDLE.
  - DATA → PARITY after 8 samples.
  - PARITY → STOP1.
  - STOP1 → STOP2 when the latched `two_stop` is 1; otherwise STOP1 → IDLE.
  - STOP2 → IDLE.
- `baud_divisor`, `two_stop` and `odd_parity` are latched on the start edge. Changing them mid-frame has no effect on the frame in progress.
- Data bits are shifted in LSB first.
- Parity check:
  - Even parity: error if `^data ^ parity_bit` is 1.
  - Odd parity: error if `^data ^ parity_bit` is 0.
- Frame error: set if any checked stop bit is sampled as 0. The entry is still pushed. A new start bit is not detected until the line has been sampled high again, which is guaranteed by the edge rule.
- Push happens on the final stop sample. The entry is {data, parity_err, frame_err}.
- FIFO full at push: the frame is discarded, `overrun_err` is set, and the FIFO contents are unchanged.
- Push and pop in the same cycle while full: the pop is applied first and the push is accepted; the count stays at `FIFO_DEPTH`.
- Push and pop in the same cycle while non-full: the count is unchanged.
- `rd_en` while the FIFO is empty is ignored.
- `err_clr` and an overrun in the same cycle: the overrun wins and `overrun_err` stays 1.
- `rx_en` deasserted: the FSM goes to IDLE on the next clock and any partial frame is discarded. The FIFO contents and flags are kept and can still be read.

## Timing
- Reset values:
  - Everything: FSM in IDLE, FIFO empty, pointers 0, the baud counter and bit counter 0.
  - `rx_data`=0, `rx_valid`=0, `rx_parity_err`=0, `rx_frame_err`=0, `overrun_err`=0, `fifo_full`=0, `fifo_count`=0, `rx_busy`=0.
  - Internal last-sample register = 1.
- Reset mid-frame aborts the frame immediately (asynchronous reset).
- Start edge sampled in cycle T: the baud counter clears and START is entered at T+1. `rx_busy` is 1 from T+1.
- Mid-start sample: taken when the counter equals `baud_divisor>>1`. The counter then clears.
- Every later sample (data, parity, stop): taken when the counter equals `baud_divisor`, i.e. every `baud_divisor+1` cycles. The counter clears on each sample.
- FIFO write happens at the clock edge of the final stop sample.
- `rx_valid`, `rx_data` and `fifo_count` update in the following cycle.
- Pop: `rd_en` high in cycle P; the next head (or `rx_valid`=0) is visible in cycle P+1.
- `overrun_err` is 1 in the cycle after the dropped push.
- `err_clr` takes effect on the next clock.

## Configuration
- `UART_RX_SYNC_EN` defined:
  - `rx_in` passes through a 2-flop synchronizer (both flops reset to 1) before edge detection and sampling.
  - All line-to-sample latencies increase by 2 cycles.
- Not defined: `rx_in` is used directly and must be synchronous to `clk`.

## Test plan
- Single frame: `baud_divisor`=15, even parity, one stop; drive 0xA5 with parity 0 and stop 1 → `rx_valid`=1, `rx_data`=0xA5, `rx_parity_err`=0, `rx_frame_err`=0, `fifo_count`=1.
- Parity and framing errors:
  - `odd_parity`=1; send 0xA5 with parity bit 0 → the entry has `rx_parity_err`=1.
  - Send 0x3C with stop bit 0 → `rx_frame_err`=1 and `rx_data`=0x3C.
- False start: a 4-cycle low glitch at `baud_divisor`=15 → FSM returns to IDLE, no push, `rx_busy` low again within 9 cycles.
- Overrun: `two_stop`=1; send 5 frames 0x01–0x05 with no reads → `fifo_full`=1, `overrun_err`=1, and the reads return 0x01–0x04. `err_clr` then clears `overrun_err`.
- Simultaneous events:
  - Pop on the exact push cycle while full → count stays 4 and `overrun_err` stays 0.
  - `rx_en` dropped in the middle of the DATA state → no push; the next frame after re-enable is received correctly.
  - `rst_n` asserted mid-frame → all outputs return to their reset values.

Source files
------------

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver with parity/framing check and FWFT receive FIFO
//
// Frame: 1 start, 8 data (LSB first), 1 parity, 1 or 2 stop bits.
// Optional build macro: UART_RX_SYNC_EN adds a 2-flop input synchronizer on rx_in.
//
// Ports:
//   clk, rst_n (async, active-high)     clock and reset
//   rx_en                               receiver enable; low aborts any frame in progress
//   baud_divisor[13:0]                  bit period = baud_divisor+1 cycles (min 3)
//   two_stop, odd_parity                frame format, latched at the start edge
//   rx_in                               serial line, idle high
//   rd_en, err_clr                      FIFO pop, overrun flag clear
//   rx_data, rx_valid, rx_parity_err,
//   rx_frame_err                        FIFO head entry
//   overrun_err, fifo_full, fifo_count  FIFO status
//   rx_busy                             FSM not idle
module uart_rx #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          rx_en,
    input  logic [13:0]                   baud_divisor,
    input  logic                          two_stop,
    input  logic                          odd_parity,
    input  logic                          rx_in,
    input  logic                          rd_en,
    input  logic                          err_clr,
    output logic [7:0]                    rx_data,
    output logic                          rx_valid,
    output logic                          rx_parity_err,
    output logic                          rx_frame_err,
    output logic                          overrun_err,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          rx_busy
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    logic line;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], rx_in};
    end
    assign line = sync_q[1];
`else
    assign line = rx_in;
`endif

    state_t      state_q, state_d;
    logic        last_q;
    logic [13:0] cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [13:0] div_q;
    logic        two_stop_q;
    logic        odd_q;
    logic [7:0]  shift_q;
    logic        perr_q;
    logic        ferr_q;

    logic        start_edge;
    logic        tick;
    logic        push_req;
    logic        push_ferr;

    assign start_edge = rx_en & last_q & ~line;
    // The start bit is sampled at half a period to centre all later samples in their bits.
    assign tick       = (state_q == S_START) ? (cnt_q == (div_q >> 1)) : (cnt_q == div_q);
    // Frame error must include the stop sample taken on the push cycle itself.
    assign push_ferr  = ferr_q | ~line;

    always_comb begin
        state_d  = state_q;
        push_req = 1'b0;
        case (state_q)
            S_IDLE:   if (start_edge) state_d = S_START;
            S_START:  if (tick) state_d = line ? S_IDLE : S_DATA;
            S_DATA:   if (tick && bit_cnt_q == 3'd7) state_d = S_PARITY;
            S_PARITY: if (tick) state_d = S_STOP1;
            S_STOP1: begin
                if (tick) begin
                    if (two_stop_q) begin
                        state_d = S_STOP2;
                    end else begin
                        state_d  = S_IDLE;
                        push_req = 1'b1;
                    end
                end
            end
            S_STOP2: begin
                if (tick) begin
                    state_d  = S_IDLE;
                    push_req = 1'b1;
                end
            end
            default:  state_d = S_IDLE;
        endcase
        if (!rx_en) begin
            state_d  = S_IDLE;
            push_req = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q    <= S_IDLE;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            bit_cnt_q  <= '0;
            div_q      <= '0;
            two_stop_q <= 1'b0;
            odd_q      <= 1'b0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            last_q  <= line;
            if (state_q == S_IDLE) begin
                cnt_q     <= '0;
                bit_cnt_q <= '0;
                if (start_edge) begin
                    div_q      <= (baud_divisor < 14'd3) ? 14'd3 : baud_divisor;
                    two_stop_q <= two_stop;
                    odd_q      <= odd_parity;
                    perr_q     <= 1'b0;
                    ferr_q     <= 1'b0;
                end
            end else begin
                cnt_q <= tick ? 14'd0 : cnt_q + 14'd1;
                if (tick) begin
                    case (state_q)
                        S_DATA: begin
                            shift_q   <= {line, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                        S_PARITY: perr_q <= ^shift_q ^ line ^ odd_q;
                        S_STOP1,
                        S_STOP2:  ferr_q <= push_ferr;
                        default:  ;
                    endcase
                end
            end
        end
    end

    // Receive FIFO: entry = {data[7:0], parity_err, frame_err}
    logic [9:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]  count_q;
    logic         overrun_q;
    logic         full;
    logic         pop;
    logic         push_ok;

    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = rd_en && (count_q != '0);
    // When full, a simultaneous pop frees the slot the push lands in.
    assign push_ok = push_req && (!full || pop);

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= {shift_q, perr_q, push_ferr};
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (push_req && !push_ok) overrun_q <= 1'b1;
            else if (err_clr)         overrun_q <= 1'b0;
        end
    end

    assign rx_data       = mem_q[rd_ptr_q][9:2];
    assign rx_parity_err = mem_q[rd_ptr_q][1];
    assign rx_frame_err  = mem_q[rd_ptr_q][0];
    assign rx_valid      = (count_q != '0);
    assign fifo_full     = full;
    assign fifo_count    = count_q;
    assign overrun_err   = overrun_q;
    assign rx_busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        rx_en = 1'b0;
    logic [13:0] baud_divisor = 14'd15;
    logic        two_stop = 1'b0;
    logic        odd_parity = 1'b0;
    logic        rx_in = 1'b1;
    logic        rd_en = 1'b0;
    logic        err_clr = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_parity_err;
    logic        rx_frame_err;
    logic        overrun_err;
    logic        fifo_full;
    logic [2:0]  fifo_count;
    logic        rx_busy;

    int total = 0;
    int passed = 0;

    uart_rx #(.FIFO_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .baud_divisor(baud_divisor),
        .two_stop(two_stop), .odd_parity(odd_parity), .rx_in(rx_in), .rd_en(rd_en),
        .err_clr(err_clr), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
        .overrun_err(overrun_err), .fifo_full(fifo_full), .fifo_count(fifo_count),
        .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // Bit period is 16 cycles (divisor 15); the DUT samples each bit at cycle offset 8.
    task automatic send_frame(input logic [7:0] d, input logic p, input logic s1,
                              input logic s2, input logic use2, input logic pop_at_push);
        logic [11:0] bits;
        int nb;
        bits = {s2, s1, p, d, 1'b0};
        nb   = use2 ? 12 : 11;
        for (int b = 0; b < nb; b++) begin
            rx_in = bits[b];
            for (int c = 0; c < 16; c++) begin
                rd_en = pop_at_push && (b == nb - 1) && (c == 8);
                step();
            end
        end
        rd_en = 1'b0;
        rx_in = 1'b1;
        repeat (4) step();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    initial begin
        int n;
        logic [7:0] d;

        // Reset state
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_data", rx_data, 0);
        check("rst_count", fifo_count, 0);
        check("rst_busy", rx_busy, 0);
        check("rst_overrun", overrun_err, 0);
        check("rst_full", fifo_full, 0);
        repeat (2) step();
        rst_n = 1'b0;
        rx_en = 1'b1;
        repeat (3) step();

        // Single good frame, even parity, one stop
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("f1_valid", rx_valid, 1);
        check("f1_data", rx_data, 8'hA5);
        check("f1_perr", rx_parity_err, 0);
        check("f1_ferr", rx_frame_err, 0);
        check("f1_count", fifo_count, 1);
        check("f1_busy", rx_busy, 0);
        pop();
        check("f1_popped", rx_valid, 0);

        // Odd parity with wrong parity bit
        odd_parity = 1'b1;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("par_data", rx_data, 8'hA5);
        check("par_perr", rx_parity_err, 1);
        check("par_ferr", rx_frame_err, 0);
        pop();
        odd_parity = 1'b0;

        // Stop bit low
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        check("frm_data", rx_data, 8'h3C);
        check("frm_ferr", rx_frame_err, 1);
        check("frm_perr", rx_parity_err, 0);
        pop();
        check("frm_empty", fifo_count, 0);

        // False start: 4-cycle glitch
        rx_in = 1'b0;
        step();
        check("fs_busy", rx_busy, 1);
        repeat (3) step();
        rx_in = 1'b1;
        n = 4;
        while (rx_busy && n < 20) begin
            step();
            n++;
        end
        check("fs_idle_within_9", (n <= 9), 1);
        repeat (30) step();
        check("fs_nopush", rx_valid, 0);

        // Overrun with two stop bits
        two_stop = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            d = 8'(i);
            send_frame(d, ^d, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        check("ovr_full", fifo_full, 1);
        check("ovr_count", fifo_count, 4);
        check("ovr_flag", overrun_err, 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovr_read", rx_data, i);
            pop();
        end
        check("ovr_drained", rx_valid, 0);
        check("ovr_sticky", overrun_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("ovr_clr", overrun_err, 0);

        // Pop on the exact push cycle while full
        for (int i = 1; i <= 4; i++) begin
            d = 8'(i * 8'h11);
            send_frame(d, ^d, 1'b1, 1'b1, 1'b1, 1'b0);
        end
        check("pp_full_before", fifo_full, 1);
        send_frame(8'h55, ^8'h55, 1'b1, 1'b1, 1'b1, 1'b1);
        check("pp_count", fifo_count, 4);
        check("pp_overrun", overrun_err, 0);
        check("pp_head", rx_data, 8'h22);
        for (int i = 2; i <= 5; i++) begin
            check("pp_drain", rx_data, i * 8'h11);
            pop();
        end
        check("pp_empty", rx_valid, 0);
        two_stop = 1'b0;

        // rx_en dropped mid-DATA
        rx_in = 1'b0;
        repeat (16 * 4 + 3) step();
        check("en_busy_mid", rx_busy, 1);
        rx_en = 1'b0;
        rx_in = 1'b1;
        step();
        check("en_abort_idle", rx_busy, 0);
        repeat (10) step();
        rx_en = 1'b1;
        repeat (200) step();
        check("en_nopush", fifo_count, 0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("en_next_data", rx_data, 8'h5A);
        check("en_next_perr", rx_parity_err, 0);
        check("en_next_count", fifo_count, 1);

        // Reset mid-frame
        odd_parity = 1'b1;
        send_frame(8'h77, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        check("rm_count_pre", fifo_count, 2);
        rx_in = 1'b0;
        repeat (40) step();
        #2;
        rst_n = 1'b1;
        #1;
        check("rm_busy", rx_busy, 0);
        check("rm_valid", rx_valid, 0);
        check("rm_data", rx_data, 0);
        check("rm_count", fifo_count, 0);
        check("rm_perr", rx_parity_err, 0);
        check("rm_ferr", rx_frame_err, 0);
        check("rm_full", fifo_full, 0);
        check("rm_overrun", overrun_err, 0);
        rx_in = 1'b1;
        step();
        rst_n = 1'b0;
        repeat (3) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
